// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and the coordinate type for the VGA sync generator.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_DISPLAY_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_DISPLAY_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;
  localparam int CLK_DIV_D   = 2;

  localparam int H_TOTAL_D      = H_DISPLAY_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D      = V_DISPLAY_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  localparam int H_SYNC_START_D = H_DISPLAY_D + H_FRONT_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
  localparam int V_SYNC_START_D = V_DISPLAY_D + V_FRONT_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

endpackage

// File: rtl/pix_tick_gen.sv
// Generic clock-enable divider: tick is high for one clk out of every CLK_DIV clks.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // tick is registered, so the first one appears CLK_DIV clks after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, registered syncs and blanking decode.
// Optional colour gating register enabled by defining VGA_SYNC_RGB_GATE_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int V_DISPLAY = V_DISPLAY_D,
  parameter int V_FRONT   = V_FRONT_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BACK    = V_BACK_D,
  parameter int CLK_DIV   = CLK_DIV_D
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_SYNC_RGB_GATE_EN
  ,
  input  logic [2:0] rgb_in,
  output logic [2:0] rgb_out
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_MAX    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_MAX    = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  coord_t h_next;
  coord_t v_next;
  logic   h_wrap;
  logic   v_wrap;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (p_tick)
  );

  always_comb begin
    h_wrap = (hcount == H_MAX);
    v_wrap = (vcount == V_MAX);
    h_next = h_wrap ? '0 : hcount + 10'd1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + 10'd1;
    end
  end

  // syncs decode the next-count values so they line up with the registered counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else if (p_tick) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
      vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
      frame_start <= h_wrap && v_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign video_on = (hcount < H_VIS) && (vcount < V_VIS);

`ifdef VGA_SYNC_RGB_GATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out <= 3'b000;
    end else begin
      rgb_out <= video_on ? rgb_in : 3'b000;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: full-size instance for line timing, reduced instances for frame timing.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       f_tick, f_hs, f_vs, f_von, f_fs;
  logic [9:0] f_h, f_v;
  logic       s_tick, s_hs, s_vs, s_von, s_fs;
  logic [9:0] s_h, s_v;
  logic       d_tick, d_hs, d_vs, d_von, d_fs;
  logic [9:0] d_h, d_v;
`ifdef VGA_SYNC_RGB_GATE_EN
  logic [2:0] rgb_in = 3'b111;
  logic [2:0] f_rgb, s_rgb, d_rgb;
`endif

  vga_sync_gen u_full (
    .clk(clk), .rst_n(rst_n), .p_tick(f_tick), .hcount(f_h), .vcount(f_v),
    .hsync(f_hs), .vsync(f_vs), .video_on(f_von), .frame_start(f_fs)
`ifdef VGA_SYNC_RGB_GATE_EN
    , .rgb_in(rgb_in), .rgb_out(f_rgb)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .p_tick(s_tick), .hcount(s_h), .vcount(s_v),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
`ifdef VGA_SYNC_RGB_GATE_EN
    , .rgb_in(rgb_in), .rgb_out(s_rgb)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(1)
  ) u_div1 (
    .clk(clk), .rst_n(rst_n), .p_tick(d_tick), .hcount(d_h), .vcount(d_v),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .frame_start(d_fs)
`ifdef VGA_SYNC_RGB_GATE_EN
    , .rgb_in(rgb_in), .rgb_out(d_rgb)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    h;
    int    v;
    int    hs;
    int    vs;
    int    von;
  } coord_exp_t;

  typedef struct {
    int full;
    int div1;
  } tick_exp_t;

  coord_exp_t q_full[$];
  coord_exp_t q_small[$];
  tick_exp_t  q_tick[$];
  int         q_line[$];
  int         q_frame[$];
  int         q_rst[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_full(input string n, input int h, input int v, input int hs, input int vs, input int von);
    coord_exp_t e;
    e.name = n; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.von = von;
    q_full.push_back(e);
  endtask

  task automatic push_small(input string n, input int h, input int v, input int hs, input int vs, input int von);
    coord_exp_t e;
    e.name = n; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.von = von;
    q_small.push_back(e);
  endtask

  // coordinate-triggered monitors: compare when the DUT presents the expected position
  always @(negedge clk) begin
    if (rst_n && q_full.size() > 0 && int'(f_h) == q_full[0].h && int'(f_v) == q_full[0].v) begin
      chk({q_full[0].name, "_hsync"}, int'(f_hs), q_full[0].hs);
      chk({q_full[0].name, "_vsync"}, int'(f_vs), q_full[0].vs);
      chk({q_full[0].name, "_video_on"}, int'(f_von), q_full[0].von);
      void'(q_full.pop_front());
    end
    if (rst_n && q_small.size() > 0 && int'(s_h) == q_small[0].h && int'(s_v) == q_small[0].v) begin
      chk({q_small[0].name, "_hsync"}, int'(s_hs), q_small[0].hs);
      chk({q_small[0].name, "_vsync"}, int'(s_vs), q_small[0].vs);
      chk({q_small[0].name, "_video_on"}, int'(s_von), q_small[0].von);
      void'(q_small.pop_front());
    end
  end

  always @(negedge clk) begin
    if (q_tick.size() > 0) begin
      chk("p_tick_div2", int'(f_tick), q_tick[0].full);
      chk("p_tick_div1", int'(d_tick), q_tick[0].div1);
      void'(q_tick.pop_front());
    end
  end

  always @(negedge rst_n) begin
    #1;
    if (q_rst.size() > 0) begin
      void'(q_rst.pop_front());
      chk("rst_hcount", int'(f_h), 0);
      chk("rst_vcount", int'(f_v), 0);
      chk("rst_hsync", int'(f_hs), 1);
      chk("rst_vsync", int'(f_vs), 1);
      chk("rst_p_tick", int'(f_tick), 0);
      chk("rst_frame_start", int'(f_fs), 0);
      chk("rst_small_h", int'(s_h), 0);
      chk("rst_small_v", int'(s_v), 0);
    end
  end

`ifdef VGA_SYNC_RGB_GATE_EN
  int  prev_on = 0;
  bit  prev_ok = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok = 0;
    end else begin
      if (prev_ok) chk("rgb_out", int'(f_rgb), prev_on ? 7 : 0);
      prev_on = (int'(f_h) < 640 && int'(f_v) < 480) ? 1 : 0;
      prev_ok = 1;
    end
  end
`endif

  // line measurement on the full-size instance, starting at h=0 after reset release
  initial begin : line_mon
    int ticks, hs_low, n;
    bit seen;
    ticks = 0; hs_low = 0; n = 0; seen = 0;
    wait (rst_n === 1'b1);
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (seen && f_h == 10'd0) break;
      if (f_tick) begin
        ticks++;
        if (!f_hs) hs_low++;
      end
      if (f_h != 10'd0) seen = 1;
    end
    if (q_line.size() > 0) begin chk("line_p_ticks", ticks, q_line[0]); void'(q_line.pop_front()); end
    if (q_line.size() > 0) begin chk("hsync_low_ticks", hs_low, q_line[0]); void'(q_line.pop_front()); end
  end

  // frame measurement on the reduced instance
  initial begin : frame_mon
    int n, last, width, starts, vs_low;
    bit prev;
    n = 0; last = -1; width = 0; starts = 0; vs_low = 0; prev = 0;
    wait (rst_n === 1'b1);
    while (starts < 2 && n < 5000) begin
      @(negedge clk);
      n++;
      if (s_tick && !s_vs && starts == 0) vs_low++;
      if (s_fs && !prev) begin
        chk("frame_start_h", int'(s_h), 0);
        chk("frame_start_v", int'(s_v), 0);
        if (q_frame.size() > 0) begin
          chk(last < 0 ? "vsync_low_ticks" : "frame_period_clk", last < 0 ? vs_low : n - last, q_frame[0]);
          void'(q_frame.pop_front());
        end
        last = n;
        starts++;
        width = 0;
      end
      if (s_fs) width++;
      if (!s_fs && prev && q_frame.size() > 0) begin
        chk("frame_start_width", width, q_frame[0]);
        void'(q_frame.pop_front());
      end
      prev = s_fs;
    end
  end

  initial begin : stim
    int n;
    tick_exp_t t;
    repeat (3) @(posedge clk);

    push_full("h639", 639, 0, 1, 1, 1);
    push_full("h640", 640, 0, 1, 1, 0);
    push_full("h655", 655, 0, 1, 1, 0);
    push_full("h656", 656, 0, 0, 1, 0);
    push_full("h751", 751, 0, 0, 1, 0);
    push_full("h752", 752, 0, 1, 1, 0);
    push_full("h799", 799, 0, 1, 1, 0);
    push_full("line1", 0, 1, 1, 1, 1);

    push_small("s15_0", 15, 0, 1, 1, 1);
    push_small("s16_0", 16, 0, 1, 1, 0);
    push_small("s17_0", 17, 0, 1, 1, 0);
    push_small("s18_0", 18, 0, 0, 1, 0);
    push_small("s20_0", 20, 0, 0, 1, 0);
    push_small("s21_0", 21, 0, 1, 1, 0);
    push_small("s0_7", 0, 7, 1, 1, 1);
    push_small("s15_7", 15, 7, 1, 1, 1);
    push_small("s0_8", 0, 8, 1, 1, 0);
    push_small("s0_9", 0, 9, 1, 1, 0);
    push_small("s0_10", 0, 10, 1, 0, 0);
    push_small("s22_11", 22, 11, 1, 0, 0);
    push_small("s0_12", 0, 12, 1, 1, 0);
    push_small("s22_14", 22, 14, 1, 1, 0);
    push_small("wrap", 0, 0, 1, 1, 1);

    q_line.push_back(800);
    q_line.push_back(96);
    q_frame.push_back(46);
    q_frame.push_back(1);
    q_frame.push_back(690);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    t.full = 0; t.div1 = 0; q_tick.push_back(t);
    for (int i = 0; i < 6; i++) begin
      t.full = i % 2; t.div1 = 1; q_tick.push_back(t);
    end

    n = 0;
    while (!(f_h == 10'd300 && f_v == 10'd1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_h300", int'(f_h), 300);
    #2;
    q_rst.push_back(1);
    rst_n = 1'b0;
    #20;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    n = 0;
    while ((q_full.size() + q_small.size() + q_tick.size() + q_line.size() + q_frame.size() + q_rst.size()) > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q_full.size() > 0)  begin errors++; $display("FAIL timeout_full pending=%0d required=0", q_full.size()); end
    if (q_small.size() > 0) begin errors++; $display("FAIL timeout_small pending=%0d required=0", q_small.size()); end
    if (q_tick.size() > 0)  begin errors++; $display("FAIL timeout_tick pending=%0d required=0", q_tick.size()); end
    if (q_line.size() > 0)  begin errors++; $display("FAIL timeout_line pending=%0d required=0", q_line.size()); end
    if (q_frame.size() > 0) begin errors++; $display("FAIL timeout_frame pending=%0d required=0", q_frame.size()); end
    if (q_rst.size() > 0)   begin errors++; $display("FAIL timeout_rst pending=%0d required=0", q_rst.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
